// File: rtl/serial_subtractor_pkg.sv
// Shared types for the bit-serial subtractor: FSM state encoding.
package serial_sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage : serial_sub_pkg

// File: rtl/serial_subtractor_if.sv
// Operand and result handshake bundle for serial_subtractor.
interface serial_subtractor_if #(
    parameter int WIDTH = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] diff;
    logic             bout;
    logic             zero;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, diff, bout, zero
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, diff, bout, zero
    );
endinterface : serial_subtractor_if

// File: rtl/serial_subtractor_half_sub.sv
// Combinational half subtractor: d = x - y (mod 2), bo = borrow out.
module half_sub (
    input  logic x,
    input  logic y,
    output logic d,
    output logic bo
);

    assign d  = x ^ y;
    assign bo = ~x & y;

endmodule : half_sub

// File: rtl/serial_subtractor.sv
// Bit-serial LSB-first unsigned subtractor: diff = a - b over WIDTH cycles,
// operands and result exchanged through valid/ready handshakes.
module serial_subtractor
    import serial_sub_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic               clk,
    input  logic               resetn,
    serial_subtractor_if.slave ifc
);

    localparam int                CNT_W    = $clog2(WIDTH);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

    state_t             state_r;
    state_t             state_nxt;
    logic [WIDTH-1:0]   a_sr_r;
    logic [WIDTH-1:0]   a_sr_nxt;
    logic [WIDTH-1:0]   b_sr_r;
    logic [WIDTH-1:0]   b_sr_nxt;
    // One bit narrower than the result: the final bit is merged directly into diff.
    logic [WIDTH-2:0]   diff_sr_r;
    logic [WIDTH-2:0]   diff_sr_nxt;
    logic [WIDTH-1:0]   diff_cat_s;
    logic               borrow_r;
    logic               borrow_nxt;
    logic               nz_r;
    logic               nz_nxt;
    logic [CNT_W-1:0]   cnt_r;
    logic [CNT_W-1:0]   cnt_nxt;
    logic               out_valid_r;
    logic               out_valid_nxt;
    logic [WIDTH-1:0]   diff_r;
    logic [WIDTH-1:0]   diff_nxt;
    logic               bout_r;
    logic               bout_nxt;
    logic               zero_r;
    logic               zero_nxt;

    logic               in_ready_s;
    logic               d1_s;
    logic               bo1_s;
    logic               d_s;
    logic               bo2_s;
    logic               borrow_step_s;

    // Full subtract step built from two half subtractors.
    half_sub u_hs_ab (
        .x  (a_sr_r[0]),
        .y  (b_sr_r[0]),
        .d  (d1_s),
        .bo (bo1_s)
    );

    half_sub u_hs_borrow (
        .x  (d1_s),
        .y  (borrow_r),
        .d  (d_s),
        .bo (bo2_s)
    );

    assign borrow_step_s = bo1_s | bo2_s;
    assign diff_cat_s    = {d_s, diff_sr_r};
    assign in_ready_s    = (state_r == IDLE) && resetn;

    assign ifc.in_ready  = in_ready_s;
    assign ifc.out_valid = out_valid_r;
    assign ifc.diff      = diff_r;
    assign ifc.bout      = bout_r;
    assign ifc.zero      = zero_r;

    // Next-state and datapath next values; every register holds by default.
    always_comb begin
        state_nxt     = state_r;
        a_sr_nxt      = a_sr_r;
        b_sr_nxt      = b_sr_r;
        diff_sr_nxt   = diff_sr_r;
        borrow_nxt    = borrow_r;
        nz_nxt        = nz_r;
        cnt_nxt       = cnt_r;
        out_valid_nxt = out_valid_r;
        diff_nxt      = diff_r;
        bout_nxt      = bout_r;
        zero_nxt      = zero_r;

        case (state_r)
            IDLE: begin
                if (ifc.in_valid && in_ready_s) begin
                    a_sr_nxt    = ifc.a;
                    b_sr_nxt    = ifc.b;
                    diff_sr_nxt = '0;
                    borrow_nxt  = 1'b0;
                    nz_nxt      = 1'b0;
                    cnt_nxt     = '0;
                    state_nxt   = RUN;
                end else begin
                    state_nxt   = IDLE;
                end
            end

            RUN: begin
                a_sr_nxt    = a_sr_r >> 1;
                b_sr_nxt    = b_sr_r >> 1;
                diff_sr_nxt = diff_cat_s[WIDTH-1:1];
                borrow_nxt  = borrow_step_s;
                nz_nxt      = nz_r | d_s;
                cnt_nxt     = cnt_r + CNT_W'(1);
                // Last bit: publish the result on the same edge that enters DONE.
                if (cnt_r == CNT_LAST) begin
                    state_nxt     = DONE;
                    out_valid_nxt = 1'b1;
                    diff_nxt      = diff_cat_s;
                    bout_nxt      = borrow_step_s;
                    zero_nxt      = ~(nz_r | d_s);
                end else begin
                    state_nxt     = RUN;
                end
            end

            DONE: begin
                if (ifc.out_ready) begin
                    state_nxt     = IDLE;
                    out_valid_nxt = 1'b0;
                end else begin
                    state_nxt     = DONE;
                end
            end

            default: begin
                state_nxt     = IDLE;
                out_valid_nxt = 1'b0;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt;
        end
    end

    // Operand/result shift registers, borrow, counter and registered outputs.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            a_sr_r      <= '0;
            b_sr_r      <= '0;
            diff_sr_r   <= '0;
            borrow_r    <= 1'b0;
            nz_r        <= 1'b0;
            cnt_r       <= '0;
            out_valid_r <= 1'b0;
            diff_r      <= '0;
            bout_r      <= 1'b0;
            zero_r      <= 1'b0;
        end else begin
            a_sr_r      <= a_sr_nxt;
            b_sr_r      <= b_sr_nxt;
            diff_sr_r   <= diff_sr_nxt;
            borrow_r    <= borrow_nxt;
            nz_r        <= nz_nxt;
            cnt_r       <= cnt_nxt;
            out_valid_r <= out_valid_nxt;
            diff_r      <= diff_nxt;
            bout_r      <= bout_nxt;
            zero_r      <= zero_nxt;
        end
    end

endmodule : serial_subtractor

// File: tb/tb_serial_subtractor.sv
// Directed and random self-checking bench for serial_subtractor (WIDTH = 8).
module tb_serial_subtractor;

    logic clk;
    logic resetn;
    int   checks   = 0;
    int   failures = 0;

    serial_subtractor_if #(.WIDTH(8)) ifc ();

    serial_subtractor #(.WIDTH(8)) dut (
        .clk    (clk),
        .resetn (resetn),
        .ifc    (ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Present operands for one accept edge, then scramble them.
    task automatic start_op(input logic [7:0] av, input logic [7:0] bv);
        ifc.a        = av;
        ifc.b        = bv;
        ifc.in_valid = 1'b1;
        check("in_ready_before_accept", 32'(ifc.in_ready), 32'd1);
        tick();
        ifc.in_valid = 1'b0;
        ifc.a        = ~av;
        ifc.b        = av ^ bv;
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        while (!ifc.out_valid && n < 20) begin
            tick();
            n++;
        end
        check(tag, 32'(n), 32'd8);
    endtask

    task automatic check_res(input string tag, input logic [7:0] ed, input logic eb, input logic ez);
        check({tag, "_valid"}, 32'(ifc.out_valid), 32'd1);
        check({tag, "_diff"},  32'(ifc.diff),      32'(ed));
        check({tag, "_bout"},  32'(ifc.bout),      32'(eb));
        check({tag, "_zero"},  32'(ifc.zero),      32'(ez));
    endtask

    task automatic release_out(input string tag);
        ifc.out_ready = 1'b1;
        tick();
        check({tag, "_valid_drop"}, 32'(ifc.out_valid), 32'd0);
        check({tag, "_in_ready"},   32'(ifc.in_ready),  32'd1);
        ifc.out_ready = 1'b0;
    endtask

    initial begin
        logic [7:0] ra;
        logic [7:0] rb;
        logic [8:0] ref9;
        int         gap;

        resetn        = 1'b0;
        ifc.in_valid  = 1'b0;
        ifc.a         = 8'd0;
        ifc.b         = 8'd0;
        ifc.out_ready = 1'b0;
        tick();
        tick();
        check("rst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("rst_in_ready",  32'(ifc.in_ready),  32'd0);
        check("rst_diff",      32'(ifc.diff),      32'd0);
        resetn = 1'b1;
        #1;
        check("rst_release_in_ready", 32'(ifc.in_ready), 32'd1);

        // Nominal operation with out_ready already high.
        ifc.out_ready = 1'b1;
        start_op(8'd100, 8'd37);
        check("run_in_ready", 32'(ifc.in_ready), 32'd0);
        wait_valid("lat_100_37");
        check_res("r100_37", 8'd63, 1'b0, 1'b0);
        check("done_in_ready", 32'(ifc.in_ready), 32'd0);
        release_out("r100_37");
        check("idle_diff_held", 32'(ifc.diff), 32'd63);

        // Reset three cycles into RUN discards the operation and clears outputs.
        start_op(8'd100, 8'd37);
        tick();
        tick();
        tick();
        resetn = 1'b0;
        #1;
        check("midrst_out_valid", 32'(ifc.out_valid), 32'd0);
        check("midrst_diff",      32'(ifc.diff),      32'd0);
        check("midrst_bout",      32'(ifc.bout),      32'd0);
        check("midrst_zero",      32'(ifc.zero),      32'd0);
        tick();
        resetn = 1'b1;
        #1;
        check("midrst_in_ready", 32'(ifc.in_ready), 32'd1);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_no_spurious", 32'(ifc.out_valid), 32'd0);
        end

        // Borrow cases.
        start_op(8'd5, 8'd9);
        wait_valid("lat_5_9");
        check_res("r5_9", 8'hFC, 1'b1, 1'b0);
        release_out("r5_9");
        start_op(8'd0, 8'hFF);
        wait_valid("lat_0_ff");
        check_res("r0_ff", 8'h01, 1'b1, 1'b0);
        release_out("r0_ff");

        // Equal operands and all-ones minus zero.
        start_op(8'hAA, 8'hAA);
        wait_valid("lat_aa_aa");
        check_res("raa_aa", 8'h00, 1'b0, 1'b1);
        release_out("raa_aa");
        start_op(8'hFF, 8'h00);
        wait_valid("lat_ff_00");
        check_res("rff_00", 8'hFF, 1'b0, 1'b0);
        release_out("rff_00");

        // Backpressure in DONE with new operands waiting.
        ifc.out_ready = 1'b0;
        start_op(8'd5, 8'd9);
        wait_valid("lat_bp");
        ifc.a        = 8'h11;
        ifc.b        = 8'h22;
        ifc.in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check_res("bp_hold", 8'hFC, 1'b1, 1'b0);
            check("bp_in_ready", 32'(ifc.in_ready), 32'd0);
        end
        ifc.out_ready = 1'b1;
        tick();
        check("bp_release_valid", 32'(ifc.out_valid), 32'd0);
        check("bp_release_ready", 32'(ifc.in_ready),  32'd1);
        ifc.out_ready = 1'b0;
        tick();
        check("bp_accepted", 32'(ifc.in_ready), 32'd0);
        ifc.in_valid = 1'b0;
        wait_valid("lat_11_22");
        check_res("r11_22", 8'hEF, 1'b1, 1'b0);
        release_out("r11_22");

        // Random operands with random consumer stalls.
        for (int i = 0; i < 100; i++) begin
            ra   = 8'($urandom);
            rb   = 8'($urandom);
            ref9 = {1'b0, ra} - {1'b0, rb};
            gap  = int'($urandom_range(0, 3));
            start_op(ra, rb);
            wait_valid("rnd_lat");
            for (int g = 0; g < gap; g++) begin
                tick();
            end
            check_res("rnd", ref9[7:0], ref9[8], (ref9[7:0] == 8'd0));
            release_out("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_serial_subtractor
